// File: rtl/wr_burst_engine.sv
// wr_burst_engine: AXI4 write master that issues one INCR burst per command.
// The AW and W channels run concurrently. Data beats pass straight through
// from the caller to the W channel without buffering, and each command
// reports a done/error status.
module wr_burst_engine #(
  parameter int ENGINE_ID  = 0,
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,  // 256 or 512 only
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    done_err,
  output logic                    m_axi_AWVALID,
  output logic [ADDR_WIDTH-1:0]   m_axi_AWADDR,
  output logic [ID_WIDTH-1:0]     m_axi_AWID,
  output logic [LEN_WIDTH-1:0]    m_axi_AWLEN,
  output logic [2:0]              m_axi_AWSIZE,
  output logic [1:0]              m_axi_AWBURST,
  input  logic                    m_axi_AWREADY,
  output logic                    m_axi_WVALID,
  output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_axi_WSTRB,
  output logic                    m_axi_WLAST,
  input  logic                    m_axi_WREADY,
  input  logic                    m_axi_BVALID,
  input  logic [1:0]              m_axi_BRESP,
  input  logic [ID_WIDTH-1:0]     m_axi_BID,
  output logic                    m_axi_BREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  // Clears the byte-offset bits so that every burst starts on a beat boundary.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));
  localparam logic [2:0] AXSIZE = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;

  typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;

  logic w_active;
  logic w_last_beat;
  logic w_hs;
  logic aw_hs;
  logic b_hs;
  // BRESP[0] only distinguishes EXOKAY from OKAY; it does not signal an error.
  logic unused_bresp0;

  assign unused_bresp0 = m_axi_BRESP[0];

  // The W channel is a pure pass-through while the burst still owes beats.
  assign w_active     = (state_q == XFER) && !w_done_q;
  assign w_last_beat  = (beat_cnt_q == len_q);
  assign m_axi_WVALID = w_active & wr_valid;
  assign wr_ready     = w_active & m_axi_WREADY;
  assign m_axi_WLAST  = w_active & w_last_beat;
  assign m_axi_WDATA  = wr_data;
  assign m_axi_WSTRB  = wr_strb;

  assign w_hs  = m_axi_WVALID & m_axi_WREADY;
  assign aw_hs = awvalid_q & m_axi_AWREADY;
  assign b_hs  = bready_q & m_axi_BVALID;

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_err      = done_err_q;
  assign m_axi_AWVALID = awvalid_q;
  assign m_axi_AWADDR  = addr_q;
  assign m_axi_AWLEN   = len_q;
  assign m_axi_AWID    = ID_WIDTH'(ENGINE_ID);
  assign m_axi_AWSIZE  = AXSIZE;
  assign m_axi_AWBURST = 2'b01;
  assign m_axi_BREADY  = bready_q;

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awvalid_d  = awvalid_q;
    bready_d   = bready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_err_d = done_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr & ALIGN_MASK;
          len_d      = cmd_len;
          beat_cnt_d = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awvalid_d  = 1'b1;
          busy_d     = 1'b1;
          done_err_d = 1'b0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          // The last beat sets w_done, so the counter never wraps mid-burst.
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (w_last_beat) begin
            w_done_d = 1'b1;
          end
        end
        // Both channels can finish in the same cycle, so look at this cycle's handshakes too.
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last_beat))) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          bready_d   = 1'b0;
          done_err_d = m_axi_BRESP[1] | (m_axi_BID != ID_WIDTH'(ENGINE_ID));
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset abandons any burst that is in flight, with no done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awvalid_q  <= awvalid_d;
      bready_q   <= bready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

endmodule

// File: tb/tb_wr_burst_engine.sv
// tb_wr_burst_engine: directed bench for wr_burst_engine. It uses the default
// parameters: 256-bit data, 8-bit length, ENGINE_ID = 0.
module tb_wr_burst_engine;

  logic         clk;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [32:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [255:0] wr_data;
  logic [31:0]  wr_strb;
  logic         wr_valid;
  logic         wr_ready;
  logic         busy;
  logic         done;
  logic         done_err;
  logic         m_axi_AWVALID;
  logic [32:0]  m_axi_AWADDR;
  logic [5:0]   m_axi_AWID;
  logic [7:0]   m_axi_AWLEN;
  logic [2:0]   m_axi_AWSIZE;
  logic [1:0]   m_axi_AWBURST;
  logic         m_axi_AWREADY;
  logic         m_axi_WVALID;
  logic [255:0] m_axi_WDATA;
  logic [31:0]  m_axi_WSTRB;
  logic         m_axi_WLAST;
  logic         m_axi_WREADY;
  logic         m_axi_BVALID;
  logic [1:0]   m_axi_BRESP;
  logic [5:0]   m_axi_BID;
  logic         m_axi_BREADY;

  int checks = 0;
  int failures = 0;

  // Observations recorded by do_burst
  int          o_aw_count, o_aw_cycles, o_aw_first_cyc;
  logic [32:0] o_aw_addr;
  logic [7:0]  o_aw_len;
  logic [1:0]  o_aw_burst;
  logic [2:0]  o_aw_size;
  logic [5:0]  o_aw_id;
  bit          o_aw_unstable, o_data_bad, o_bready_early, o_timeout;
  int          o_beats, o_wlast_count, o_last_idx;
  int          o_done_count, o_done_lat;
  logic        o_done_err, o_ready0, o_busy1, o_ready_after, o_busy_after;

  wr_burst_engine dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .done_err(done_err),
    .m_axi_AWVALID(m_axi_AWVALID), .m_axi_AWADDR(m_axi_AWADDR), .m_axi_AWID(m_axi_AWID),
    .m_axi_AWLEN(m_axi_AWLEN), .m_axi_AWSIZE(m_axi_AWSIZE), .m_axi_AWBURST(m_axi_AWBURST),
    .m_axi_AWREADY(m_axi_AWREADY),
    .m_axi_WVALID(m_axi_WVALID), .m_axi_WDATA(m_axi_WDATA), .m_axi_WSTRB(m_axi_WSTRB),
    .m_axi_WLAST(m_axi_WLAST), .m_axi_WREADY(m_axi_WREADY),
    .m_axi_BVALID(m_axi_BVALID), .m_axi_BRESP(m_axi_BRESP), .m_axi_BID(m_axi_BID),
    .m_axi_BREADY(m_axi_BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one command against a simple slave model and records what is seen on the bus.
  // Inputs are driven 1 time unit after the rising edge and outputs are sampled 1 unit later.
  task automatic do_burst(input logic [32:0] addr, input logic [7:0] len, input int aw_delay,
                          input bit wtoggle, input logic [1:0] bresp, input logic [5:0] bid);
    int cyc, post, aw_wait, bhs_cyc;
    bit aw_hs_seen, done_seen;
    o_aw_count = 0; o_aw_cycles = 0; o_aw_first_cyc = -1; o_aw_unstable = 0;
    o_aw_addr = '0; o_aw_len = '0; o_aw_burst = '0; o_aw_size = '0; o_aw_id = '0;
    o_data_bad = 0; o_bready_early = 0; o_beats = 0; o_wlast_count = 0; o_last_idx = -1;
    o_done_count = 0; o_done_lat = -1; o_done_err = 1'bx;
    o_ready0 = 0; o_busy1 = 0; o_ready_after = 0; o_busy_after = 1;
    aw_hs_seen = 0; done_seen = 0; aw_wait = 0; bhs_cyc = -100; post = 0; cyc = 0;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    m_axi_BRESP = bresp; m_axi_BID = bid;
    while (cyc < 2000 && post < 4) begin
      m_axi_AWREADY = (aw_wait >= aw_delay);
      m_axi_WREADY  = wtoggle ? cyc[0] : 1'b1;
      m_axi_BVALID  = 1'b1;
      wr_valid = 1'b1;
      wr_data  = {8{o_beats}};
      wr_strb  = '1;
      #1;
      if (cyc == 0) o_ready0 = cmd_ready;
      if (cyc == 1) o_busy1 = busy;
      if (m_axi_BREADY && !aw_hs_seen) o_bready_early = 1;
      if (m_axi_AWVALID) begin
        if (o_aw_cycles == 0) begin
          o_aw_addr = m_axi_AWADDR; o_aw_len = m_axi_AWLEN; o_aw_burst = m_axi_AWBURST;
          o_aw_size = m_axi_AWSIZE; o_aw_id = m_axi_AWID; o_aw_first_cyc = cyc;
        end else if (m_axi_AWADDR != o_aw_addr || m_axi_AWLEN != o_aw_len) begin
          o_aw_unstable = 1;
        end
        o_aw_cycles++; aw_wait++;
        if (m_axi_AWREADY) begin o_aw_count++; aw_hs_seen = 1; end
      end
      if (m_axi_WVALID && m_axi_WREADY) begin
        if (m_axi_WDATA !== wr_data || m_axi_WSTRB !== wr_strb) o_data_bad = 1;
        if (m_axi_WLAST) begin o_wlast_count++; o_last_idx = o_beats; end
        o_beats++;
      end
      if (m_axi_BVALID && m_axi_BREADY) bhs_cyc = cyc;
      if (done) begin
        o_done_count++; o_done_err = done_err; o_done_lat = cyc - bhs_cyc; done_seen = 1;
      end
      if (post == 1) begin o_ready_after = cmd_ready; o_busy_after = busy; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cyc++;
      if (done_seen) post++;
    end
    o_timeout = !done_seen;
    m_axi_BVALID = 1'b0; wr_valid = 1'b0; m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b0;
    $display("burst addr=0x%0h len=%0d aw=%0d beats=%0d wlast=%0d done=%0d err=%0b cycles=%0d",
             addr, len, o_aw_count, o_beats, o_wlast_count, o_done_count, o_done_err, cyc);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (m_axi_AWVALID !== 1'b0) begin failures++; $display("FAIL reset_awvalid got=%0b exp=0", m_axi_AWVALID); end
    checks++; if (m_axi_BREADY !== 1'b0) begin failures++; $display("FAIL reset_bready got=%0b exp=0", m_axi_BREADY); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0 || done_err !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b/%0b exp=0/0", done, done_err); end
    checks++; if (m_axi_WVALID !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL reset_w got=%0b/%0b exp=0/0", m_axi_WVALID, wr_ready); end
    resetn = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    do_burst(33'h1000, 8'd3, 0, 1'b0, 2'b00, 6'd0);
    checks++; if (o_ready0 !== 1'b1) begin failures++; $display("FAIL basic_cmd_ready got=%0b exp=1", o_ready0); end
    checks++; if (o_busy1 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", o_busy1); end
    checks++; if (o_aw_first_cyc != 1) begin failures++; $display("FAIL basic_aw_latency got=%0d exp=1", o_aw_first_cyc); end
    checks++; if (o_aw_count != 1) begin failures++; $display("FAIL basic_aw_count got=%0d exp=1", o_aw_count); end
    checks++; if (o_aw_addr !== 33'h1000) begin failures++; $display("FAIL basic_awaddr got=0x%0h exp=0x1000", o_aw_addr); end
    checks++; if (o_aw_len !== 8'd3) begin failures++; $display("FAIL basic_awlen got=%0d exp=3", o_aw_len); end
    checks++; if (o_aw_burst !== 2'b01 || o_aw_size !== 3'b101 || o_aw_id !== 6'd0) begin failures++; $display("FAIL basic_aw_attr got=%0b/%0b/%0d exp=01/101/0", o_aw_burst, o_aw_size, o_aw_id); end
    checks++; if (o_beats != 4) begin failures++; $display("FAIL basic_beats got=%0d exp=4", o_beats); end
    checks++; if (o_wlast_count != 1 || o_last_idx != 3) begin failures++; $display("FAIL basic_wlast got=%0d@%0d exp=1@3", o_wlast_count, o_last_idx); end
    checks++; if (o_data_bad) begin failures++; $display("FAIL basic_wdata got=corrupt exp=pass-through"); end
    checks++; if (o_done_count != 1 || o_done_err !== 1'b0) begin failures++; $display("FAIL basic_done got=%0d/%0b exp=1/0", o_done_count, o_done_err); end
    checks++; if (o_done_lat != 1) begin failures++; $display("FAIL basic_done_latency got=%0d exp=1", o_done_lat); end
    checks++; if (o_ready_after !== 1'b1 || o_busy_after !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%0b/%0b exp=1/0", o_ready_after, o_busy_after); end
  endtask

  task automatic test_align_single();
    do_burst(33'h103F, 8'd0, 0, 1'b0, 2'b00, 6'd0);
    checks++; if (o_aw_addr !== 33'h1020) begin failures++; $display("FAIL align_awaddr got=0x%0h exp=0x1020", o_aw_addr); end
    checks++; if (o_aw_len !== 8'd0) begin failures++; $display("FAIL align_awlen got=%0d exp=0", o_aw_len); end
    checks++; if (o_beats != 1 || o_wlast_count != 1 || o_last_idx != 0) begin failures++; $display("FAIL single_beat got=%0d/%0d@%0d exp=1/1@0", o_beats, o_wlast_count, o_last_idx); end
    checks++; if (o_done_count != 1 || o_done_err !== 1'b0) begin failures++; $display("FAIL single_done got=%0d/%0b exp=1/0", o_done_count, o_done_err); end
  endtask

  task automatic test_aw_backpressure();
    do_burst(33'h2000, 8'd3, 10, 1'b0, 2'b00, 6'd0);
    checks++; if (o_aw_cycles != 11) begin failures++; $display("FAIL awbp_valid_cycles got=%0d exp=11", o_aw_cycles); end
    checks++; if (o_aw_unstable) begin failures++; $display("FAIL awbp_stable got=changed exp=stable"); end
    checks++; if (o_bready_early) begin failures++; $display("FAIL awbp_bready_order got=early exp=after_aw"); end
    checks++; if (o_beats != 4 || o_last_idx != 3) begin failures++; $display("FAIL awbp_beats got=%0d@%0d exp=4@3", o_beats, o_last_idx); end
    checks++; if (o_aw_count != 1 || o_done_count != 1) begin failures++; $display("FAIL awbp_done got=%0d/%0d exp=1/1", o_aw_count, o_done_count); end
  endtask

  task automatic test_wready_toggle();
    do_burst(33'h3000, 8'd5, 0, 1'b1, 2'b00, 6'd0);
    checks++; if (o_beats != 6) begin failures++; $display("FAIL wtog_beats got=%0d exp=6", o_beats); end
    checks++; if (o_wlast_count != 1 || o_last_idx != 5) begin failures++; $display("FAIL wtog_wlast got=%0d@%0d exp=1@5", o_wlast_count, o_last_idx); end
    checks++; if (o_data_bad) begin failures++; $display("FAIL wtog_wdata got=corrupt exp=pass-through"); end
    checks++; if (o_done_count != 1 || o_done_err !== 1'b0) begin failures++; $display("FAIL wtog_done got=%0d/%0b exp=1/0", o_done_count, o_done_err); end
  endtask

  task automatic test_error();
    do_burst(33'h4000, 8'd1, 0, 1'b0, 2'b10, 6'd0);
    checks++; if (o_done_count != 1 || o_done_err !== 1'b1) begin failures++; $display("FAIL slverr_done got=%0d/%0b exp=1/1", o_done_count, o_done_err); end
    checks++; if (o_aw_count != 1) begin failures++; $display("FAIL slverr_aw_count got=%0d exp=1", o_aw_count); end
    do_burst(33'h4100, 8'd1, 0, 1'b0, 2'b00, 6'd1);
    checks++; if (o_done_count != 1 || o_done_err !== 1'b1) begin failures++; $display("FAIL bid_mismatch got=%0d/%0b exp=1/1", o_done_count, o_done_err); end
  endtask

  task automatic test_back_to_back();
    do_burst(33'h5000, 8'd2, 0, 1'b0, 2'b01, 6'd0);
    checks++; if (o_done_count != 1 || o_done_err !== 1'b0) begin failures++; $display("FAIL b2b_exokay got=%0d/%0b exp=1/0", o_done_count, o_done_err); end
    checks++; if (o_ready0 !== 1'b1 || o_beats != 3) begin failures++; $display("FAIL b2b_accept got=%0b/%0d exp=1/3", o_ready0, o_beats); end
  endtask

  task automatic test_max_len();
    do_burst(33'h10000, 8'd255, 0, 1'b0, 2'b00, 6'd0);
    checks++; if (o_beats != 256) begin failures++; $display("FAIL maxlen_beats got=%0d exp=256", o_beats); end
    checks++; if (o_wlast_count != 1 || o_last_idx != 255) begin failures++; $display("FAIL maxlen_wlast got=%0d@%0d exp=1@255", o_wlast_count, o_last_idx); end
    checks++; if (o_aw_len !== 8'd255 || o_timeout) begin failures++; $display("FAIL maxlen_done got=%0d/%0b exp=255/0", o_aw_len, o_timeout); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_addr = 33'h6000; cmd_len = 8'd7;
    m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b1; m_axi_BVALID = 1'b0;
    wr_valid = 1'b1; wr_data = '0; wr_strb = '1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_axi_AWVALID !== 1'b1 || m_axi_WVALID !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0b/%0b exp=1/1", m_axi_AWVALID, m_axi_WVALID); end
    resetn = 1'b0;
    #1;
    checks++; if (m_axi_AWVALID !== 1'b0 || m_axi_WVALID !== 1'b0 || m_axi_BREADY !== 1'b0) begin failures++; $display("FAIL midrst_bus got=%0b/%0b/%0b exp=0/0/0", m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%0b/%0b exp=1/0", cmd_ready, busy); end
    @(posedge clk); #1;
    resetn = 1'b1;
    m_axi_AWREADY = 1'b1; m_axi_BVALID = 1'b1; m_axi_BRESP = 2'b00; m_axi_BID = 6'd0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones != 0 || m_axi_AWVALID !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%0d/%0b exp=0/0", dones, m_axi_AWVALID); end
    m_axi_AWREADY = 1'b0; m_axi_BVALID = 1'b0; wr_valid = 1'b0;
    $display("mid-burst reset abandoned burst, done pulses=%0d", dones);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
    m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b0; m_axi_BVALID = 1'b0;
    m_axi_BRESP = 2'b00; m_axi_BID = '0;
    test_reset();
    test_basic();
    test_align_single();
    test_aw_backpressure();
    test_wready_toggle();
    test_error();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
